// File: rtl/pm_rate_meter.sv
`default_nettype none
// ============================================================================
// Module      : pm_rate_meter
// Description : Windowed receive-side rate meter: frame/byte count, min/max gap
// Revision    : 1.0 - initial release
// ============================================================================
module pm_rate_meter #(
  parameter int SIZE          = 64,
  parameter int WINDOW_CYCLES = 17920,
  parameter int COUNT_WIDTH   = 32,
  parameter int GAP_WIDTH     = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              enable_i,
  input  logic                              frame_in_i,
  output logic                              result_valid_o,
  output logic [COUNT_WIDTH-1:0]            frame_count_o,
  output logic [COUNT_WIDTH+$clog2(SIZE):0] byte_count_o,
  output logic [GAP_WIDTH-1:0]              gap_min_o,
  output logic [GAP_WIDTH-1:0]              gap_max_o,
  output logic                              gap_sat_o
);

  localparam int BYTE_WIDTH = COUNT_WIDTH + $clog2(SIZE) + 1;
  localparam int WIN_WIDTH  = $clog2(WINDOW_CYCLES);

  localparam logic [WIN_WIDTH-1:0]   C_WIN_LAST = WIN_WIDTH'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] C_CNT_MAX  = '1;
  localparam logic [BYTE_WIDTH-1:0]  C_BYTE_MAX = '1;
  localparam logic [BYTE_WIDTH-1:0]  C_BYTE_INC = BYTE_WIDTH'(SIZE);
  localparam logic [GAP_WIDTH-1:0]   C_GAP_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e                  state_q;
  logic [WIN_WIDTH-1:0]    win_cnt_q;
  logic [COUNT_WIDTH-1:0]  frame_acc_q, frame_acc_d;
  logic [BYTE_WIDTH-1:0]   byte_acc_q, byte_acc_d;
  logic [GAP_WIDTH-1:0]    gap_cnt_q, gap_cnt_d;
  logic [GAP_WIDTH-1:0]    gmin_acc_q, gmin_acc_d;
  logic [GAP_WIDTH-1:0]    gmax_acc_q, gmax_acc_d;
  logic                    gsat_acc_q, gsat_acc_d;

  logic                    result_valid_q;
  logic [COUNT_WIDTH-1:0]  frame_count_q;
  logic [BYTE_WIDTH-1:0]   byte_count_q;
  logic [GAP_WIDTH-1:0]    gap_min_q, gap_max_q;
  logic                    gap_sat_q;

  // Window accumulators including the current cycle's strobe; a gap is only
  // meaningful once a previous strobe exists, i.e. in RUN.
  always_comb begin
    frame_acc_d = frame_acc_q;
    byte_acc_d  = byte_acc_q;
    gmin_acc_d  = gmin_acc_q;
    gmax_acc_d  = gmax_acc_q;
    gsat_acc_d  = gsat_acc_q;
    gap_cnt_d   = (gap_cnt_q == C_GAP_MAX) ? gap_cnt_q : gap_cnt_q + GAP_WIDTH'(1);
    if (frame_in_i) begin
      gap_cnt_d = GAP_WIDTH'(1);
      if (frame_acc_q != C_CNT_MAX) frame_acc_d = frame_acc_q + COUNT_WIDTH'(1);
      if (byte_acc_q > (C_BYTE_MAX - C_BYTE_INC)) byte_acc_d = C_BYTE_MAX;
      else                                        byte_acc_d = byte_acc_q + C_BYTE_INC;
      if (state_q == S_RUN) begin
        if (gap_cnt_q < gmin_acc_q) gmin_acc_d = gap_cnt_q;
        if (gap_cnt_q > gmax_acc_q) gmax_acc_d = gap_cnt_q;
        if (gap_cnt_q == C_GAP_MAX) gsat_acc_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      win_cnt_q      <= '0;
      frame_acc_q    <= '0;
      byte_acc_q     <= '0;
      gap_cnt_q      <= '0;
      gmin_acc_q     <= C_GAP_MAX;
      gmax_acc_q     <= '0;
      gsat_acc_q     <= 1'b0;
      result_valid_q <= 1'b0;
      frame_count_q  <= '0;
      byte_count_q   <= '0;
      gap_min_q      <= C_GAP_MAX;
      gap_max_q      <= '0;
      gap_sat_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            state_q     <= S_ARMED;
            win_cnt_q   <= '0;
            frame_acc_q <= '0;
            byte_acc_q  <= '0;
            gmin_acc_q  <= C_GAP_MAX;
            gmax_acc_q  <= '0;
            gsat_acc_q  <= 1'b0;
          end
        end
        S_ARMED: begin
          if (!enable_i) begin
            state_q <= S_IDLE;
          end else if (frame_in_i) begin
            // The first strobe is window cycle 0.
            state_q     <= S_RUN;
            win_cnt_q   <= WIN_WIDTH'(1);
            frame_acc_q <= frame_acc_d;
            byte_acc_q  <= byte_acc_d;
            gap_cnt_q   <= gap_cnt_d;
          end
        end
        S_RUN: begin
          if (!enable_i) begin
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_d;
            if (win_cnt_q == C_WIN_LAST) begin
              win_cnt_q      <= '0;
              result_valid_q <= 1'b1;
              frame_count_q  <= frame_acc_d;
              byte_count_q   <= byte_acc_d;
              gap_min_q      <= gmin_acc_d;
              gap_max_q      <= gmax_acc_d;
              gap_sat_q      <= gsat_acc_d;
              frame_acc_q    <= '0;
              byte_acc_q     <= '0;
              gmin_acc_q     <= C_GAP_MAX;
              gmax_acc_q     <= '0;
              gsat_acc_q     <= 1'b0;
            end else begin
              win_cnt_q   <= win_cnt_q + WIN_WIDTH'(1);
              frame_acc_q <= frame_acc_d;
              byte_acc_q  <= byte_acc_d;
              gmin_acc_q  <= gmin_acc_d;
              gmax_acc_q  <= gmax_acc_d;
              gsat_acc_q  <= gsat_acc_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result_valid_o = result_valid_q;
  assign frame_count_o  = frame_count_q;
  assign byte_count_o   = byte_count_q;
  assign gap_min_o      = gap_min_q;
  assign gap_max_o      = gap_max_q;
  assign gap_sat_o      = gap_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_pm_rate_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pm_rate_meter
// Description : Scoreboard bench for pm_rate_meter (default and small-window DUTs)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pm_rate_meter;

  localparam int A_WIN = 17920;
  localparam int B_WIN = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en_a  = 1'b0, fr_a = 1'b0, en_b = 1'b0, fr_b = 1'b0;
  logic rv_a, rv_b, gs_a, gs_b;
  logic [31:0] fc_a;
  logic [38:0] bc_a;
  logic [15:0] gmin_a, gmax_a;
  logic [7:0]  fc_b;
  logic [14:0] bc_b;
  logic [7:0]  gmin_b, gmax_b;

  int it    = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] at;
    logic [63:0] fc;
    logic [63:0] bc;
    logic [15:0] gmin;
    logic [15:0] gmax;
    logic        gs;
  } res_t;

  res_t qa[$];
  res_t qb[$];

  always #5 clk = ~clk;

  pm_rate_meter u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en_a), .frame_in_i(fr_a),
    .result_valid_o(rv_a), .frame_count_o(fc_a), .byte_count_o(bc_a),
    .gap_min_o(gmin_a), .gap_max_o(gmax_a), .gap_sat_o(gs_a)
  );

  pm_rate_meter #(.SIZE(64), .WINDOW_CYCLES(B_WIN), .COUNT_WIDTH(8), .GAP_WIDTH(8)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en_b), .frame_in_i(fr_b),
    .result_valid_o(rv_b), .frame_count_o(fc_b), .byte_count_o(bc_b),
    .gap_min_o(gmin_b), .gap_max_o(gmax_b), .gap_sat_o(gs_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
    it++;
  endtask

  function automatic res_t mk(input int at, input longint fc, input longint bc,
                              input int gmin, input int gmax, input bit gs);
    res_t r;
    r.at = 32'(at); r.fc = 64'(fc); r.bc = 64'(bc);
    r.gmin = 16'(gmin); r.gmax = 16'(gmax); r.gs = gs;
    return r;
  endfunction

  function automatic res_t obs_a();
    return mk(it, longint'(fc_a), longint'(bc_a), int'(gmin_a), int'(gmax_a), gs_a);
  endfunction

  function automatic res_t obs_b();
    return mk(it, longint'(fc_b), longint'(bc_b), int'(gmin_b), int'(gmax_b), gs_b);
  endfunction

  function automatic string str(input res_t r);
    return $sformatf("at=%0d fc=%0d bc=%0d gmin=%0d gmax=%0d sat=%0b",
                     r.at, r.fc, r.bc, r.gmin, r.gmax, r.gs);
  endfunction

  task automatic test_reset();
    res_t e, o;
    int j;
    en_b = 1'b1; fr_b = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; o = obs_a(); o.at = '0; e = mk(0, 0, 0, 16'hFFFF, 0, 1'b0);
    if (o !== e || rv_a !== 1'b0) begin
      n_err++; $display("FAIL reset_a: got %s rv=%b want %s rv=0", str(o), rv_a, str(e));
    end
    n_cmp++; o = obs_b(); o.at = '0; e = mk(0, 0, 0, 8'hFF, 0, 1'b0);
    if (o !== e || rv_b !== 1'b0) begin
      n_err++; $display("FAIL reset_b: got %s rv=%b want %s rv=0", str(o), rv_b, str(e));
    end
    step(); step();
    // enable already high at release: IDLE, then ARMED, then first strobe
    j = it; rst_n = 1'b1;
    qb.push_back(mk(j + B_WIN + 1, 255, 32767, 1, 1, 1'b0));
    while (it <= j + B_WIN + 2) begin
      if (rv_b) begin
        n_cmp++;
        if (qb.size() == 0) begin
          n_err++; $display("FAIL reset_release: got result_valid at %0d want none", it);
        end else begin
          e = qb.pop_front(); o = obs_b();
          if (o !== e) begin n_err++; $display("FAIL reset_release: got %s want %s", str(o), str(e)); end
        end
      end
      step();
    end
    fr_b = 1'b0; en_b = 1'b0; step();
    n_cmp++;
    if (qb.size() != 0) begin
      n_err++; $display("FAIL reset_release_pending: got %0d outstanding want 0", qb.size()); qb.delete();
    end
  endtask

  task automatic test_paced();
    int per [10] = '{180, 180, 179, 179, 179, 179, 179, 179, 179, 179};
    int s, nxt, k;
    res_t e, o;
    en_a = 1'b0; step(); step(); en_a = 1'b1; step(); step();
    s = it; nxt = s; k = 0;
    qa.push_back(mk(s + A_WIN,     100, 6400, 179, 180, 1'b0));
    qa.push_back(mk(s + 2 * A_WIN, 100, 6400, 179, 180, 1'b0));
    while (it <= s + 2 * A_WIN + 2) begin
      if (rv_a) begin
        n_cmp++;
        if (qa.size() == 0) begin
          n_err++; $display("FAIL paced: got result_valid at %0d want none", it);
        end else begin
          e = qa.pop_front(); o = obs_a();
          if (o !== e) begin n_err++; $display("FAIL paced: got %s want %s", str(o), str(e)); end
        end
      end
      if (it == nxt && it < s + 2 * A_WIN) begin
        fr_a = 1'b1; nxt += per[k % 10]; k++;
      end else begin
        fr_a = 1'b0;
      end
      step();
    end
    fr_a = 1'b0; en_a = 1'b0; step();
    n_cmp++;
    if (qa.size() != 0) begin
      n_err++; $display("FAIL paced_pending: got %0d outstanding want 0", qa.size()); qa.delete();
    end
  endtask

  task automatic test_back_to_back();
    int s;
    res_t e, o;
    en_a = 1'b0; step(); step(); en_a = 1'b1; step(); step();
    s = it;
    qa.push_back(mk(s + A_WIN, A_WIN, A_WIN * 64, 1, 1, 1'b0));
    while (it <= s + A_WIN + 1) begin
      if (rv_a) begin
        n_cmp++;
        if (qa.size() == 0) begin
          n_err++; $display("FAIL back_to_back: got result_valid at %0d want none", it);
        end else begin
          e = qa.pop_front(); o = obs_a();
          if (o !== e) begin n_err++; $display("FAIL back_to_back: got %s want %s", str(o), str(e)); end
        end
      end
      fr_a = (it < s + A_WIN);
      step();
    end
    fr_a = 1'b0; en_a = 1'b0; step();
    n_cmp++;
    if (qa.size() != 0) begin
      n_err++; $display("FAIL back_to_back_pending: got %0d outstanding want 0", qa.size()); qa.delete();
    end
  endtask

  task automatic test_gap_sat();
    int s;
    res_t e, o;
    en_b = 1'b0; step(); step(); en_b = 1'b1; step(); step();
    s = it;
    qb.push_back(mk(s + B_WIN,     1, 64, 255, 0,   1'b0));
    qb.push_back(mk(s + 2 * B_WIN, 1, 64, 255, 255, 1'b1));
    while (it <= s + 2 * B_WIN + 1) begin
      if (rv_b) begin
        n_cmp++;
        if (qb.size() == 0) begin
          n_err++; $display("FAIL gap_sat: got result_valid at %0d want none", it);
        end else begin
          e = qb.pop_front(); o = obs_b();
          if (o !== e) begin n_err++; $display("FAIL gap_sat: got %s want %s", str(o), str(e)); end
        end
      end
      fr_b = (it == s || it == s + 1300);
      step();
    end
    fr_b = 1'b0; en_b = 1'b0; step();
    n_cmp++;
    if (qb.size() != 0) begin
      n_err++; $display("FAIL gap_sat_pending: got %0d outstanding want 0", qb.size()); qb.delete();
    end
  endtask

  task automatic test_close_boundary();
    int s;
    res_t e, o;
    en_b = 1'b0; step(); step(); en_b = 1'b1; step(); step();
    s = it;
    qb.push_back(mk(s + B_WIN,     3, 192, 99, 255, 1'b1));
    qb.push_back(mk(s + 2 * B_WIN, 2, 128, 1,  10,  1'b0));
    while (it <= s + 2 * B_WIN + 1) begin
      if (rv_b) begin
        n_cmp++;
        if (qb.size() == 0) begin
          n_err++; $display("FAIL close_boundary: got result_valid at %0d want none", it);
        end else begin
          e = qb.pop_front(); o = obs_b();
          if (o !== e) begin n_err++; $display("FAIL close_boundary: got %s want %s", str(o), str(e)); end
        end
      end
      fr_b = (it == s || it == s + 900 || it == s + B_WIN - 1 || it == s + B_WIN || it == s + B_WIN + 10);
      step();
    end
    fr_b = 1'b0; en_b = 1'b0; step();
    n_cmp++;
    if (qb.size() != 0) begin
      n_err++; $display("FAIL close_boundary_pending: got %0d outstanding want 0", qb.size()); qb.delete();
    end
  endtask

  task automatic test_enable_drop();
    int s;
    res_t e, o;
    en_b = 1'b0; step(); step(); en_b = 1'b1; step(); step();
    s = it;
    while (it <= s + 1500) begin
      if (rv_b) begin
        n_cmp++; n_err++;
        $display("FAIL enable_drop: got result_valid at %0d want none", it);
      end
      if (it == s + 500) en_b = 1'b0;
      fr_b = (it < s + 500) && ((it - s) % 7 == 0);
      step();
    end
    n_cmp++; o = obs_b(); o.at = '0; e = mk(0, 2, 128, 1, 10, 1'b0);
    if (o !== e) begin n_err++; $display("FAIL enable_drop_hold: got %s want %s", str(o), str(e)); end
    en_b = 1'b1; step(); step();
    s = it;
    qb.push_back(mk(s + B_WIN, 250, 16000, 4, 4, 1'b0));
    while (it <= s + B_WIN + 1) begin
      if (rv_b) begin
        n_cmp++;
        if (qb.size() == 0) begin
          n_err++; $display("FAIL reenable: got result_valid at %0d want none", it);
        end else begin
          e = qb.pop_front(); o = obs_b();
          if (o !== e) begin n_err++; $display("FAIL reenable: got %s want %s", str(o), str(e)); end
        end
      end
      fr_b = (it < s + B_WIN) && ((it - s) % 4 == 0);
      step();
    end
    fr_b = 1'b0; en_b = 1'b0; step();
    n_cmp++;
    if (qb.size() != 0) begin
      n_err++; $display("FAIL reenable_pending: got %0d outstanding want 0", qb.size()); qb.delete();
    end
  endtask

  task automatic test_reset_midrun();
    int s;
    res_t e, o;
    en_a = 1'b0; step(); en_a = 1'b1; step(); step();
    s = it;
    while (it < s + 100) begin
      fr_a = ((it - s) % 3 == 0);
      step();
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; o = obs_a(); o.at = '0; e = mk(0, 0, 0, 16'hFFFF, 0, 1'b0);
    if (o !== e || rv_a !== 1'b0) begin
      n_err++; $display("FAIL reset_midrun_a: got %s rv=%b want %s rv=0", str(o), rv_a, str(e));
    end
    n_cmp++; o = obs_b(); o.at = '0; e = mk(0, 0, 0, 8'hFF, 0, 1'b0);
    if (o !== e || rv_b !== 1'b0) begin
      n_err++; $display("FAIL reset_midrun_b: got %s rv=%b want %s rv=0", str(o), rv_b, str(e));
    end
    fr_a = 1'b0; en_a = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_paced();
    test_back_to_back();
    test_gap_sat();
    test_close_boundary();
    test_enable_drop();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
